// File: rtl/mul8s_share_arb.sv
// Round-robin arbiter sharing one external 8x8 signed multiplier.
// A one-entry output slot registers the product with its requester id.
module mul8s_share_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_a,
   input  logic [8*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           mul_a,
   output logic [7:0]           mul_b,
   input  logic [15:0]          mul_o,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [15:0]          rsp_data,
   output logic [15:0]          op_count
);

   typedef enum logic {EMPTY, FULL} state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [15:0]       rsp_data_q, rsp_data_d;
   logic [15:0]       op_count_q, op_count_d;
   logic [7:0]        mul_a_q, mul_a_d;
   logic [7:0]        mul_b_q, mul_b_d;

   logic [2*NUM_REQ-1:0] rot;
   logic [ID_W:0]        sum;
   logic [ID_W-1:0]      gidx;
   logic [7:0]           a_sel, b_sel;
   logic                 slot_free, xfer, drain;

   assign rsp_valid = (state_q == FULL);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign op_count  = op_count_q;

   assign slot_free = ~rsp_valid | rsp_ready;
   assign drain     = rsp_valid & rsp_ready;
   assign xfer      = (|req_valid) & slot_free & rst_n;

   // Find the first valid requester at or above rr_ptr, wrapping
   always_comb begin
      rot = {req_valid, req_valid} >> rr_ptr_q;
      sum = {1'b0, rr_ptr_q};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      end
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      gidx = sum[ID_W-1:0];
   end

   assign req_ready = xfer ? (NUM_REQ'(1) << gidx) : '0;

   // Route granted operands; idle cycles keep the last pair stable
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            a_sel = req_a[8*i +: 8];
            b_sel = req_b[8*i +: 8];
         end
      end
   end

   assign mul_a = xfer ? a_sel : mul_a_q;
   assign mul_b = xfer ? b_sel : mul_b_q;

   // Slot state transitions and next values for the datapath
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      mul_a_d    = mul_a_q;
      mul_b_d    = mul_b_q;
      op_count_d = op_count_q + 16'(drain);
      unique case (state_q)
         EMPTY: if (xfer) state_d = FULL;
         FULL:  if (drain && !xfer) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
      if (xfer) begin
         rsp_data_d = mul_o;
         rsp_id_d   = gidx;
         mul_a_d    = a_sel;
         mul_b_d    = b_sel;
         rr_ptr_d   = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         rr_ptr_q   <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         op_count_q <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         op_count_q <= op_count_d;
         mul_a_q    <= mul_a_d;
         mul_b_q    <= mul_b_d;
      end
   end

endmodule
